// File: rtl/inst_encoder.sv
// Gumnut instruction encoder: packs decoded fields into 18-bit words and
// writes them to instruction memory at an auto-incrementing address.
module inst_encoder #(
  parameter logic [11:0] BASE_RST  = 12'h000,
  parameter logic [11:0] LAST_ADDR = 12'hFFF
) (
  input  logic        clkg,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_func,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rs2,
  input  logic [7:0]  in_imm,
  input  logic [2:0]  in_count,
  input  logic [11:0] in_addr,
  input  logic        load_base,
  input  logic [11:0] base_addr,
  input  logic        clr_err,
  output logic        imem_we,
  output logic [11:0] imem_addr,
  output logic [17:0] imem_data,
  output logic        err,
  output logic        full,
  output logic [12:0] words
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 18;
  localparam int unsigned WW = 13;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] data_q, data_d;
  logic [WW-1:0] words_q, words_d;
  logic          err_q, err_d;
  logic          full_q, full_d;

  logic [DW-1:0] enc_c;
  logic          legal_c;
  logic          accept_c;

  // Field packing and legality for the presented bundle
  always_comb begin
    enc_c   = '0;
    legal_c = 1'b1;
    case (in_class)
      3'd0: enc_c = {1'b0, in_func, in_rd, in_rs, in_imm};
      3'd1: begin
        legal_c = ~in_func[2];
        enc_c   = {2'b10, in_func[1:0], in_rd, in_rs, in_imm};
      end
      3'd2: begin
        legal_c = ~in_func[2];
        enc_c   = {3'b110, 1'b0, in_rd, in_rs, in_count, 3'b000, in_func[1:0]};
      end
      3'd3: enc_c = {4'b1110, in_rd, in_rs, in_rs2, 2'b00, in_func};
      3'd4: begin
        legal_c = (in_func[2:1] == 2'b00);
        enc_c   = {5'b11110, in_func[0], in_addr};
      end
      3'd5: begin
        legal_c = ~in_func[2];
        enc_c   = {6'b111110, in_func[1:0], 2'b00, in_imm};
      end
      3'd6: enc_c = {7'b1111110, in_func, 8'h00};
      default: legal_c = 1'b0;
    endcase
  end

  // A pending base load or a full memory blocks new bundles
  assign in_ready = (state_q == IDLE) & ~full_q & ~load_base;
  assign accept_c = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    words_d = words_q;
    full_d  = full_q;
    err_d   = err_q & ~clr_err;
    case (state_q)
      IDLE: begin
        if (load_base) begin
          ptr_d   = base_addr;
          full_d  = 1'b0;
          words_d = '0;
        end else if (accept_c) begin
          if (legal_c) begin
            data_d  = enc_c;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (load_base) begin
          ptr_d   = base_addr;
          full_d  = 1'b0;
          words_d = '0;
        end else begin
          words_d = words_q + WW'(1);
          if (ptr_q == LAST_ADDR) full_d = 1'b1;
          else                    ptr_d  = ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkg) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE_RST;
      data_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      words_q <= words_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

  // Strobe drops immediately when reset lands on a write cycle
  assign imem_we   = (state_q == WRITE) & ~rst;
  assign imem_addr = ptr_q;
  assign imem_data = data_q;
  assign err       = err_q;
  assign full      = full_q;
  assign words     = words_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed table, corner sequences and
// random bundles checked against an arithmetic encoding model.
module tb_inst_encoder;

  localparam int unsigned LIMIT = 20;

  logic        clkg = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class, in_func, in_rd, in_rs, in_rs2, in_count;
  logic [7:0]  in_imm;
  logic [11:0] in_addr;
  logic        load_base;
  logic [11:0] base_addr;
  logic        clr_err;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [17:0] imem_data;
  logic        err;
  logic        full;
  logic [12:0] words;

  inst_encoder dut (
    .clkg(clkg), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_func(in_func), .in_rd(in_rd), .in_rs(in_rs),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_count(in_count), .in_addr(in_addr),
    .load_base(load_base), .base_addr(base_addr), .clr_err(clr_err),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .err(err), .full(full), .words(words)
  );

  always #5 clkg = ~clkg;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  func;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rs2;
    logic [7:0]  imm;
    logic [2:0]  count;
    logic [11:0] addr;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic [17:0] exp;
    bit          legal;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural state
  int unsigned m_ptr, m_words;
  bit          m_full, m_err;
  logic [17:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input int c, input int f, input int rd, input int rs,
                                 input int rs2, input int imm, input int cnt, input int a);
    bundle_t b;
    b.cls = 3'(c); b.func = 3'(f); b.rd = 3'(rd); b.rs = 3'(rs); b.rs2 = 3'(rs2);
    b.imm = 8'(imm); b.count = 3'(cnt); b.addr = 12'(a);
    return b;
  endfunction

  // Encoding computed as weighted field sums from the instruction format table
  function automatic void model(input bundle_t b, output logic [17:0] w, output bit legal);
    int unsigned f, rd, rs, rs2, imm, cnt, a, v;
    f = int'(b.func); rd = int'(b.rd); rs = int'(b.rs); rs2 = int'(b.rs2);
    imm = int'(b.imm); cnt = int'(b.count); a = int'(b.addr);
    legal = 1'b1;
    v = 0;
    case (int'(b.cls))
      0: v = f * 16384 + rd * 2048 + rs * 256 + imm;
      1: begin legal = (f < 4); v = 2 * 65536 + (f % 4) * 16384 + rd * 2048 + rs * 256 + imm; end
      2: begin legal = (f < 4); v = 6 * 32768 + rd * 2048 + rs * 256 + cnt * 32 + (f % 4); end
      3: v = 14 * 16384 + rd * 2048 + rs * 256 + rs2 * 32 + f;
      4: begin legal = (f < 2); v = 30 * 8192 + (f % 2) * 4096 + a; end
      5: begin legal = (f < 4); v = 62 * 4096 + (f % 4) * 1024 + imm; end
      6: v = 126 * 2048 + f * 256;
      default: legal = 1'b0;
    endcase
    w = 18'(v);
  endfunction

  task automatic drive(input bundle_t b);
    in_class = b.cls; in_func = b.func; in_rd = b.rd; in_rs = b.rs; in_rs2 = b.rs2;
    in_imm = b.imm; in_count = b.count; in_addr = b.addr;
    in_valid = 1'b1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_words = 0; m_full = 0; m_err = 0; m_data = '0;
  endtask

  // Called just after a rising edge; returns just after a rising edge
  task automatic send(input bundle_t b, input logic [17:0] exp, input bit legal, input bit with_clr);
    int n;
    drive(b);
    clr_err = with_clr;
    n = 0;
    @(negedge clkg);
    while (!in_ready && n < LIMIT) begin
      @(negedge clkg);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      clr_err = 1'b0;
      @(posedge clkg); #1;
      return;
    end
    @(posedge clkg); #1;
    in_valid = 1'b0;
    clr_err = 1'b0;
    if (legal) begin
      @(negedge clkg);
      chk("write_we", 32'(imem_we), 32'd1);
      chk("write_addr", 32'(imem_addr), 32'(m_ptr));
      chk("write_data", 32'(imem_data), 32'(exp));
      chk("ready_in_write", 32'(in_ready), 32'd0);
      @(posedge clkg); #1;
      m_data = exp;
      m_words++;
      if (with_clr) m_err = 0;
      if (m_ptr == 12'hFFF) m_full = 1;
      else m_ptr++;
    end else begin
      m_err = 1;
      @(negedge clkg);
      chk("illegal_no_we", 32'(imem_we), 32'd0);
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_ptr", 32'(imem_addr), 32'(m_ptr));
      @(posedge clkg); #1;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clkg);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(m_ptr));
    chk({tag, "_data"}, 32'(imem_data), 32'(m_data));
    chk({tag, "_words"}, 32'(words), 32'(m_words));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_ready"}, 32'(in_ready), 32'(!m_full));
    @(posedge clkg); #1;
  endtask

  vec_t vecs[10];

  initial begin
    bundle_t     b;
    logic [17:0] w;
    bit          lg;

    vecs[0] = '{mk(0, 0, 1, 2, 0, 8'h05, 0, 0),     18'h00A05, 1'b1};
    vecs[1] = '{mk(4, 1, 0, 0, 0, 0, 0, 12'h123),   18'h3D123, 1'b1};
    vecs[2] = '{mk(5, 2, 0, 0, 0, 8'h10, 0, 0),     18'h3E810, 1'b1};
    vecs[3] = '{mk(2, 3, 3, 4, 0, 0, 5, 0),         18'h31CA3, 1'b1};
    vecs[4] = '{mk(3, 4, 2, 1, 7, 0, 0, 0),         18'h391E4, 1'b1};
    vecs[5] = '{mk(1, 2, 5, 0, 0, 8'hFF, 0, 0),     18'h2A8FF, 1'b1};
    vecs[6] = '{mk(6, 5, 0, 0, 0, 0, 0, 0),         18'h3F500, 1'b1};
    vecs[7] = '{mk(7, 0, 1, 1, 1, 8'h11, 1, 1),     18'h00000, 1'b0};
    vecs[8] = '{mk(1, 4, 1, 2, 0, 8'h33, 0, 0),     18'h00000, 1'b0};
    vecs[9] = '{mk(4, 2, 0, 0, 0, 0, 0, 12'hABC),   18'h00000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; load_base = 1'b0; base_addr = '0; clr_err = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clkg);
    #1 rst = 1'b0;
    check_state("reset");

    // Directed vectors, applied back to back
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].b, vecs[i].exp, vecs[i].legal, 1'b0);
      check_state($sformatf("vec%0d", i));
    end

    // Sticky error: plain clear, then set-over-clear
    clr_err = 1'b1;
    @(posedge clkg); #1;
    clr_err = 1'b0;
    m_err = 0;
    check_state("clr_err");
    send(vecs[7].b, vecs[7].exp, 1'b0, 1'b0);
    send(vecs[8].b, vecs[8].exp, 1'b0, 1'b1);
    check_state("set_wins");
    clr_err = 1'b1;
    @(posedge clkg); #1;
    clr_err = 1'b0;
    m_err = 0;

    // Fill to the top of memory, stall, then reload the base
    load_base = 1'b1; base_addr = 12'hFFE;
    @(negedge clkg);
    chk("load_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clkg); #1;
    load_base = 1'b0;
    m_ptr = 12'hFFE; m_words = 0; m_full = 0;
    check_state("load_ffe");
    send(vecs[0].b, vecs[0].exp, 1'b1, 1'b0);
    send(vecs[3].b, vecs[3].exp, 1'b1, 1'b0);
    check_state("full");
    chk("full_model", 32'(m_full), 32'(full));
    drive(vecs[5].b);
    repeat (4) begin
      @(negedge clkg);
      chk("stall_we", 32'(imem_we), 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clkg); #1;
    load_base = 1'b1; base_addr = 12'h010;
    @(negedge clkg);
    chk("reload_ready", 32'(in_ready), 32'd0);
    chk("reload_we", 32'(imem_we), 32'd0);
    @(posedge clkg); #1;
    load_base = 1'b0;
    m_ptr = 12'h010; m_words = 0; m_full = 0;
    send(vecs[5].b, vecs[5].exp, 1'b1, 1'b0);
    check_state("after_reload");

    // Random bundles against the model
    for (int i = 0; i < 40; i++) begin
      b = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
      model(b, w, lg);
      send(b, w, lg, 1'b0);
      if (i % 8 == 7) check_state($sformatf("rand%0d", i));
    end

    // Reset landing on a write cycle
    send(vecs[7].b, vecs[7].exp, 1'b0, 1'b0);
    drive(vecs[1].b);
    @(negedge clkg);
    chk("pre_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clkg); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clkg);
    chk("rst_we_same_cycle", 32'(imem_we), 32'd0);
    @(posedge clkg); #1;
    rst = 1'b0;
    model_reset();
    check_state("rst_mid_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Packs decoded Gumnut instruction fields into 18-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the instruction-register field decode, and serves as the program loader/self-test generator feeding the core's instruction memory.
- Fields are accepted through a valid/ready handshake.
- Each word is range-checked, encoded, then written at an auto-incrementing 12-bit address.

Parameters:
- BASE_RST, 12'h000, write pointer value after reset.
- LAST_ADDR, 12'hFFF, highest writable address; writing it sets full.

Ports:
- clkg  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_class  in  3  0 alu_imm, 1 mem, 2 shift, 3 alu_reg, 4 jump, 5 branch, 6 misc, 7 illegal
- in_func  in  3  function code within class
- in_rd  in  3  destination register
- in_rs  in  3  source register
- in_rs2  in  3  second source register (alu_reg)
- in_imm  in  8  immediate / displacement
- in_count  in  3  shift count
- in_addr  in  12  jump target
- load_base  in  1  load write pointer from base_addr
- base_addr  in  12  new pointer value
- clr_err  in  1  clear sticky error
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  12  write address
- imem_data  out  18  encoded instruction
- err  out  1  sticky: illegal bundle rejected
- full  out  1  LAST_ADDR written, no further accepts
- words  out  13  count of words written since reset/load_base

Behaviour:
- Reset values:
  - state IDLE; pointer BASE_RST; words 0.
  - in_ready 1; imem_we 0; imem_addr BASE_RST; imem_data 0; err 0; full 0.
- Encoding, registered at accept. Bit ranges are [17:0]; all unlisted bits are 0.
  - alu_imm: [17]=0, [16:14]=func, [13:11]=rd, [10:8]=rs, [7:0]=imm.
  - mem: [17:16]=10, [15:14]=func[1:0], rd, rs, [7:0]=imm.
  - shift: [17:15]=110, rd, rs, [7:5]=count, [1:0]=func[1:0].
  - alu_reg: [17:14]=1110, rd, rs, [7:5]=rs2, [2:0]=func.
  - jump: [17:13]=11110, [12]=func[0], [11:0]=addr.
  - branch: [17:12]=111110, [11:10]=func[1:0], [7:0]=imm.
  - misc: [17:11]=1111110, [10:8]=func.
- Legality checks:
  - Illegal if class=7.
  - Illegal if func>3 for mem, shift or branch.
  - Illegal if func>1 for jump.
- FSM states IDLE and WRITE.
  - IDLE: in_ready = ~full & ~load_base.
  - Accept = in_valid & in_ready.
  - Legal accept: latch encoded word into imem_data, go to WRITE.
  - Illegal accept: set err, no write, stay IDLE. The bundle is consumed.
- WRITE (one cycle):
  - imem_we=1, imem_addr=pointer, in_ready=0.
  - Next edge: words+1. If pointer==LAST_ADDR, set full and hold the pointer; else pointer+1. Return to IDLE.
- Throughput: one word per 2 cycles. Latency: accept edge -> imem_we high the following cycle.
- imem_addr always reflects the pointer. imem_data holds its last value when imem_we=0.
- load_base:
  - In IDLE: pointer<=base_addr, full<=0, words<=0. It blocks accept that cycle.
  - In WRITE: the write completes first (pointer update suppressed), then the load is applied.
- clr_err clears err. If an illegal accept occurs in the same cycle, set wins.
- rst mid-WRITE: the write strobe is dropped and all state returns to reset values.
- in_valid while in_ready=0 is ignored. The source must hold the bundle until it is accepted.

Test Plan:
- Reset, then alu_imm func0 rd1 rs2 imm05 -> one cycle later imem_we=1, addr 000, data 18'h00A05; words=1, addr 001.
- Back-to-back valid for jump func1 addr123, then branch func2 imm10 -> data 3D123 @000, 3E810 @001. in_ready low during each WRITE.
- shift func3 rd3 rs4 count5 -> 31CA3; alu_reg func4 rd2 rs1 rs2=7 -> 391E4; mem func2 rd5 rs0 imm FF -> 2A8FF; misc func5 -> 3F500.
- class7, and mem with func=4 -> no imem_we, err=1, pointer unchanged. clr_err -> err=0. Illegal accept concurrent with clr_err -> err stays 1.
- load_base FFE, then write 3 legal bundles -> writes @FFE and @FFF, full=1, in_ready=0, third bundle stalls. load_base 010 -> full=0, third writes @010.
- rst asserted in WRITE cycle -> imem_we=0 that cycle onward, pointer 000, words 0, err 0.
